// File: rtl/mac_accum_stage.sv
// -----------------------------------------------------------------------------
// mac_accum_stage
//
// Frame-based multiply-accumulate stage. Operand pairs (a, b) are accepted over
// a valid/ready handshake, multiplied by a 16x16 unsigned combinational
// multiplier on the accepting cycle, registered, and summed into a wide
// accumulator. Once the last product of a frame has been added, the sum is
// presented on acc_out with out_valid and held until out_ready.
//
// Optional feature (compile-time macro MAC_ACCUM_SAT_EN):
//   defined   - the accumulator saturates at all-ones. The ovf port flags the
//               clamp and holds it through the result hand-off.
//   undefined - the accumulator wraps modulo 2^ACC_W. There is no ovf port.
//
// Parameters:
//   ACC_W  accumulator / result width (>= 32)
//   CNT_W  frame-length counter width; a frame holds 1..2^CNT_W beats
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   stage can accept an operand pair
//   a, b       16-bit unsigned operands
//   len        frame length, sampled on the first beat (0 means 2^CNT_W)
//   out_valid  frame result valid
//   out_ready  downstream accepts the result
//   acc_out    frame sum of products
//   busy       high whenever the stage is not idle
//   ovf        (MAC_ACCUM_SAT_EN only) the frame sum saturated
// -----------------------------------------------------------------------------
module mac_accum_stage #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [CNT_W-1:0] len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
`ifdef MAC_ACCUM_SAT_EN
  output logic             ovf,
`endif
  output logic             busy
);

  // One extra bit so the counter and the length can both hold 2^CNT_W.
  localparam int FW = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [FW-1:0]    len_reg;
  logic [FW-1:0]    count_reg;
  logic [31:0]      prod_reg;
  logic             prod_v_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [31:0]      mult_prod;
  logic [FW-1:0]    len_ext;
  logic             accept;
  logic             first_beat;

  // 16x16 unsigned combinational multiplier, fed straight from the input port.
  assign mult_prod = 32'(a) * 32'(b);

  // A length field of zero encodes the largest frame, 2^CNT_W beats.
  assign len_ext    = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
  assign accept     = in_valid & in_ready;
  assign first_beat = accept & (state_reg == IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = (count_reg < len_reg);
        // count already includes the beat whose product is in prod_reg, so a
        // valid product with count at the frame length is the final one; it is
        // added at this edge and the result is ready next cycle.
        if (prod_v_reg && (count_reg == len_reg)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Product register and frame counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg   <= '0;
      prod_v_reg <= 1'b0;
      len_reg    <= '0;
      count_reg  <= '0;
    end else begin
      prod_v_reg <= accept;
      if (accept) begin
        prod_reg <= mult_prod;
      end
      if (first_beat) begin
        len_reg   <= len_ext;
        count_reg <= FW'(1);
      end else if (accept) begin
        count_reg <= count_reg + FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator
  // ---------------------------------------------------------------------------
`ifdef MAC_ACCUM_SAT_EN
  logic             ovf_reg;
  logic [ACC_W:0]   sum_ext;

  assign sum_ext = {1'b0, acc_reg} + (ACC_W + 1)'(prod_reg);

  // Once clamped the accumulator stays at all-ones for the rest of the frame.
  always_comb begin
    acc_next = sum_ext[ACC_W-1:0];
    if (sum_ext[ACC_W] || ovf_reg) begin
      acc_next = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (first_beat) begin
      ovf_reg <= 1'b0;
    end else if (prod_v_reg && sum_ext[ACC_W]) begin
      ovf_reg <= 1'b1;
    end
  end

  assign ovf = ovf_reg;
`else
  // Wraps modulo 2^ACC_W.
  assign acc_next = acc_reg + ACC_W'(prod_reg);
`endif

  // The first beat never coincides with a pending product: HOLD always
  // separates frames, so the clear and the add are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (first_beat) begin
      acc_reg <= '0;
    end else if (prod_v_reg) begin
      acc_reg <= acc_next;
    end
  end

  assign acc_out = acc_reg;

endmodule

// File: tb/tb_mac_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_mac_accum_stage
//
// Self-checking bench for mac_accum_stage. Frames are driven at the falling
// edge; the expected frame sum comes from plain arithmetic over the operand
// list (wrapping or saturating depending on MAC_ACCUM_SAT_EN).
// -----------------------------------------------------------------------------
module tb_mac_accum_stage;

  localparam int CNT_W = 8;
`ifdef MAC_ACCUM_SAT_EN
  localparam int ACC_W = 33;
`else
  localparam int ACC_W = 40;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      a = '0;
  logic [15:0]      b = '0;
  logic [CNT_W-1:0] len = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
`ifdef MAC_ACCUM_SAT_EN
  logic             ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int unsigned qa[$];
  int unsigned qb[$];

  mac_accum_stage #(
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .len      (len),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
`ifdef MAC_ACCUM_SAT_EN
    .ovf      (ovf),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one frame from qa/qb, then check latency, result, hold and hand-off.
  task automatic run_frame(input int len_field, input int gap, input bit gap_fixed, input int hold);
    int n;
    int t_acc;
    int w;
    int g;
    longint unsigned total;
    longint unsigned max_val;
    longint unsigned exp_sum;
    bit exp_ovf;

    n = (len_field == 0) ? (1 << CNT_W) : len_field;
    total = 0;
    for (int i = 0; i < n; i++) begin
      total += longint'(qa[i]) * longint'(qb[i]);
    end
    max_val = (64'd1 << ACC_W) - 1;
`ifdef MAC_ACCUM_SAT_EN
    exp_ovf = (total > max_val);
    exp_sum = exp_ovf ? max_val : total;
`else
    exp_ovf = 1'b0;
    exp_sum = total & max_val;
`endif

    t_acc = 0;
    for (int i = 0; i < n; i++) begin
      g = gap_fixed ? gap : ((gap > 0) ? int'($urandom_range(gap, 0)) : 0);
      if (i > 0) begin
        repeat (g) begin
          in_valid = 1'b0;
          a = 16'($urandom);
          b = 16'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      a   = 16'(qa[i]);
      b   = 16'(qb[i]);
      len = (i == 0) ? CNT_W'(len_field) : CNT_W'($urandom);
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        check_val("in_ready_timeout", 64'(in_ready), 64'd1);
      end
      t_acc = cyc;
      @(negedge clk);
    end

    // Cycle T+1: keep offering junk that must be ignored.
    in_valid = 1'b1;
    a   = 16'($urandom);
    b   = 16'($urandom);
    len = CNT_W'($urandom);
    check_val("t1_cycle", 64'(cyc), 64'(t_acc + 1));
    check_val("t1_in_ready", 64'(in_ready), 64'd0);
    check_val("t1_out_valid", 64'(out_valid), 64'd0);
    check_val("t1_busy", 64'(busy), 64'd1);

    // Cycle T+2: result presented.
    @(negedge clk);
    check_val("t2_out_valid", 64'(out_valid), 64'd1);
    check_val("t2_acc_out", 64'(acc_out), exp_sum);
    check_val("t2_in_ready", 64'(in_ready), 64'd0);
`ifdef MAC_ACCUM_SAT_EN
    check_val("t2_ovf", 64'(ovf), 64'(exp_ovf));
`endif
    $display("frame len=%0d beats=%0d last_accept=%0d acc_out=%0d expected=%0d ovf_exp=%0d",
             len_field, n, t_acc, acc_out, exp_sum, exp_ovf);

    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_val("hold_out_valid", 64'(out_valid), 64'd1);
      check_val("hold_acc_out", 64'(acc_out), exp_sum);
`ifdef MAC_ACCUM_SAT_EN
      check_val("hold_ovf", 64'(ovf), 64'(exp_ovf));
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("idle_out_valid", 64'(out_valid), 64'd0);
    check_val("idle_busy", 64'(busy), 64'd0);
    check_val("idle_in_ready", 64'(in_ready), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd1);
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_acc_out", 64'(acc_out), 64'd0);
`ifdef MAC_ACCUM_SAT_EN
    check_val("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // len=1 single beat.
    qa = '{3}; qb = '{5};
    run_frame(1, 0, 1'b1, 0);

    // len=4 back-to-back with out_ready high immediately.
    qa = '{1, 2, 4, 65535}; qb = '{1, 3, 5, 65535};
    run_frame(4, 0, 1'b1, 0);

    // len=3 with two idle cycles between beats.
    qa = '{10, 10, 10}; qb = '{10, 10, 10};
    run_frame(3, 2, 1'b1, 0);

    // len=0: 256 maximal beats, 5 cycles of backpressure.
    qa.delete(); qb.delete();
    for (int i = 0; i < 256; i++) begin
      qa.push_back(65535);
      qb.push_back(65535);
    end
    run_frame(0, 0, 1'b1, 5);

`ifdef MAC_ACCUM_SAT_EN
    // Saturation then recovery on the next frame.
    qa = '{65535, 65535, 65535}; qb = '{65535, 65535, 65535};
    run_frame(3, 0, 1'b1, 2);
    qa = '{1}; qb = '{1};
    run_frame(1, 0, 1'b1, 0);
`endif

    // Randomized frames with random gaps and backpressure.
    for (int f = 0; f < 8; f++) begin
      int l;
      l = int'($urandom_range(12, 1));
      qa.delete(); qb.delete();
      for (int i = 0; i < l; i++) begin
        qa.push_back($urandom_range(65535, 0));
        qb.push_back($urandom_range(65535, 0));
      end
      run_frame(l, 2, 1'b0, int'($urandom_range(3, 0)));
    end

    // Reset mid-frame after the 2nd beat of a len=4 frame.
    in_valid = 1'b1; a = 16'd9; b = 16'd9; len = CNT_W'(4);
    @(negedge clk);
    a = 16'd11; b = 16'd12;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("mid_rst_acc_out", 64'(acc_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa = '{7}; qb = '{8};
    run_frame(1, 0, 1'b1, 1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accum_stage.md
Name: mac_accum_stage

Overview:
- Sequential multiply-accumulate stage that sits directly downstream of the 16x16 unsigned combinational multiplier and consumes its 32-bit product.
- Accepts a frame of LEN operand pairs over a valid/ready handshake and registers each product.
- Accumulates the products into a wide accumulator and presents the frame sum on a valid/ready output.
- The block instantiates the multiplier internally; operands are applied to it directly from the input port on the accepting cycle.

Parameters:
- ACC_W, 40, accumulator and result width (must be >= 32).
- CNT_W, 8, frame-length counter width; a frame holds 1..2^CNT_W beats.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage can accept an operand pair.
- a  input  16  unsigned multiplicand.
- b  input  16  unsigned multiplier.
- len  input  CNT_W  frame length, sampled on the first beat of a frame; 0 means 2^CNT_W.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts result.
- acc_out  output  ACC_W  frame sum of products.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, acc_out=0, busy=0. Internal registers cleared: prod_q=0, prod_v=0, count=0, acc=0.
- Reset asserted mid-frame aborts the frame immediately. No partial result is ever emitted.
- A beat is accepted on a cycle with in_valid & in_ready.
- FSM:
  - IDLE: in_ready=1. On an accepted beat: latch len (0 -> 2^CNT_W), set count=1, clear acc to 0, go to ACCUM.
  - ACCUM: in_ready=1 while count < frame length, else 0. Each accepted beat increments count.
  - ACCUM exit: after the product of the final beat has been added, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, acc_out stable. On out_ready go to IDLE and drop out_valid next cycle.
- Pipeline:
  - At the edge ending an accepting cycle: prod_q <= a*b (32 bits from the multiplier), prod_v <= 1. Otherwise prod_v <= 0.
  - At the edge where prod_v=1: acc <= acc + zero-extended prod_q.
- Latency: final beat accepted in cycle T -> product registered at T+1 -> accumulated, out_valid=1 in cycle T+2.
- len=1 from IDLE: beat in cycle T, out_valid at T+2. The FSM passes through ACCUM with in_ready=0 during T+1.
- Gapped input: in_valid low during ACCUM stalls without penalty. The accumulator only adds when prod_v=1.
- HOLD backpressure: out_valid held indefinitely; acc_out must not change.
- Next frame: the first beat of the next frame can be accepted in the cycle after the out_valid & out_ready handshake (IDLE). There is no overlap with HOLD.
- a, b and len are ignored while in_ready=0.
- Arithmetic: unsigned. With defaults the sum cannot overflow (255*... max 256*(2^16-1)^2 < 2^40).
- ACC_W < 40 with the macro absent: the sum wraps modulo 2^ACC_W.
- acc_out is driven from acc. It is only meaningful while out_valid=1 and is 0 after reset.

Optional Feature:
- Macro: MAC_ACCUM_SAT_EN.
- Defined: an addition whose true result exceeds 2^ACC_W-1 clamps acc to all-ones and stays clamped for the rest of the frame. Also adds output port ovf (1 bit), which is set with the clamp, held through HOLD, cleared on the first beat of the next frame, and is 0 after reset.
- Undefined: the sum wraps modulo 2^ACC_W and no ovf port exists.

Test Plan:
- Reset, then len=1, single beat a=3, b=5 in cycle T -> out_valid rises at T+2, acc_out=15, in_ready=0 at T+1 and T+2.
- len=4, back-to-back beats (1,1), (2,3), (4,5), (65535,65535) with out_ready=1 -> acc_out=4294836252 (1+6+20+4294836225); out_valid exactly 2 cycles after the 4th acceptance, high for 1 cycle.
- len=3 with in_valid gaps of 2 idle cycles between beats (10,10) x3 -> acc_out=300; count unaffected by gaps; 4th in_valid ignored until back in IDLE.
- len=0, 256 beats of (65535,65535), out_ready held 0 for 5 cycles -> acc_out=256*4294836225=1099478073600, stable for all 5 HOLD cycles; IDLE after handshake.
- Assert rst_n=0 after the 2nd beat of a len=4 frame -> in the same cycle out_valid=0, busy=0, in_ready=1; a following len=1 frame (7,8) yields 56.
- MAC_ACCUM_SAT_EN with ACC_W=33, len=3, beats (65535,65535) x3 -> acc_out=8589934591, ovf=1; next frame (1,1), len=1 -> acc_out=1, ovf=0.
